// File: rtl/bp_pkg.sv
// Shared types and helpers for the tournament branch predictor: FSM states,
// default geometry, saturating arithmetic and the table index hash.
package bp_pkg;

  typedef enum logic {INIT, RUN} bp_state_e;

  localparam int unsigned PC_W_DEF  = 32;
  localparam int unsigned IDX_W_DEF = 8;
  localparam int unsigned GHR_W_DEF = 8;
  localparam int unsigned LHR_W_DEF = 8;
  localparam int unsigned CTR_W_DEF = 2;
  localparam int unsigned CHO_W_DEF = 2;
  localparam int unsigned CNT_W_DEF = 32;

  function automatic logic [63:0] sat_max(input int unsigned width);
    return (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
  endfunction

  function automatic logic [63:0] sat_inc(input logic [63:0] value, input int unsigned width);
    return (value >= sat_max(width)) ? sat_max(width) : value + 64'd1;
  endfunction

  function automatic logic [63:0] sat_dec(input logic [63:0] value, input int unsigned width);
    return (value == 64'd0) ? 64'd0 : ((value - 64'd1) & sat_max(width));
  endfunction

  // History is zero-extended or truncated to the index width by the mask.
  function automatic logic [63:0] bp_hash(input logic [63:0] pc, input logic [63:0] hist,
                                          input int unsigned idx_w);
    return (pc ^ hist) & sat_max(idx_w);
  endfunction

endpackage

// File: rtl/bp_sat_table.sv
// One-read, one-write table of W-bit entries: saturating counters, or history
// shift registers when SHIFT=1. The init port overrides the update port.
module bp_sat_table
  import bp_pkg::*;
#(
  parameter int unsigned   IDX_W    = 8,
  parameter int unsigned   W        = 2,
  parameter bit            SHIFT    = 1'b0,
  parameter logic [W-1:0]  INIT_VAL = '0
) (
  input  logic             clk_i,
  input  logic             init_i,
  input  logic [IDX_W-1:0] init_idx_i,
  input  logic [IDX_W-1:0] rd_idx_i,
  output logic [W-1:0]     rd_data_o,
  input  logic             wr_en_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  logic             wr_bit_i,
  output logic [W-1:0]     wr_old_o
);

  localparam int unsigned DEPTH = 1 << IDX_W;

  logic [W-1:0]     mem_q [DEPTH];
  logic [W-1:0]     upd_val;
  logic             we_d;
  logic [IDX_W-1:0] widx_d;
  logic [W-1:0]     wdata_d;

  assign rd_data_o = mem_q[rd_idx_i];
  assign wr_old_o  = mem_q[wr_idx_i];

  // wr_bit_i is the shifted-in outcome for histories, the count direction otherwise.
  if (SHIFT) begin : g_shift
    assign upd_val = {wr_old_o[W-2:0], wr_bit_i};
  end else begin : g_ctr
    assign upd_val = wr_bit_i ? W'(sat_inc(64'(wr_old_o), W))
                              : W'(sat_dec(64'(wr_old_o), W));
  end

  always_comb begin
    we_d    = 1'b0;
    widx_d  = wr_idx_i;
    wdata_d = upd_val;
    if (init_i) begin
      we_d    = 1'b1;
      widx_d  = init_idx_i;
      wdata_d = INIT_VAL;
    end else if (wr_en_i) begin
      we_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (we_d) begin
      mem_q[widx_d] <= wdata_d;
    end
  end

endmodule

// File: rtl/tournament_bp.sv
// Tournament branch predictor: gshare and per-PC local-history components picked
// by a per-PC chooser, with GHR checkpoint repair and post-reset table init.
module tournament_bp
  import bp_pkg::*;
#(
  parameter int unsigned PC_W  = PC_W_DEF,
  parameter int unsigned IDX_W = IDX_W_DEF,
  parameter int unsigned GHR_W = GHR_W_DEF,
  parameter int unsigned LHR_W = LHR_W_DEF,
  parameter int unsigned CTR_W = CTR_W_DEF,
  parameter int unsigned CHO_W = CHO_W_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_n,
  output logic             ready_o,
  input  logic             F_valid_i,
  input  logic             F_is_branch_i,
  input  logic [PC_W-1:0]  F_PC_i,
  output logic             F_predict_o,
  output logic             F_global_predict_o,
  output logic             F_local_predict_o,
  output logic [GHR_W-1:0] F_ghr_o,
  input  logic             ED_redirect_i,
  input  logic [GHR_W-1:0] ED_ghr_i,
  input  logic             ED_taken_i,
  input  logic             MD_valid_i,
  input  logic [PC_W-1:0]  MD_PC_i,
  input  logic [GHR_W-1:0] MD_ghr_i,
  input  logic             MD_taken_i,
  input  logic             MD_global_predict_i,
  input  logic             MD_local_predict_i,
  output logic [CNT_W-1:0] stat_branches_o,
  output logic [CNT_W-1:0] stat_mispred_o
);

  localparam logic [CTR_W-1:0] PHT_INIT = CTR_W'((1 << (CTR_W - 1)) - 1);
  localparam logic [CHO_W-1:0] CHO_INIT = CHO_W'((1 << (CHO_W - 1)) - 1);

  bp_state_e        state_q, state_d;
  logic [IDX_W-1:0] init_idx_q, init_idx_d;
  logic [GHR_W-1:0] ghr_q, ghr_d;
  logic [CNT_W-1:0] stat_branches_q, stat_branches_d;
  logic [CNT_W-1:0] stat_mispred_q, stat_mispred_d;

  logic             run, init;
  logic [IDX_W-1:0] f_pc, md_pc, f_gidx, f_lidx, md_gidx, md_lidx;
  logic [CTR_W-1:0] f_gctr, f_lctr, md_gold, md_lold;
  logic [CHO_W-1:0] f_cho, md_cho_old;
  logic [LHR_W-1:0] f_bht, md_bht;
  logic             md_train, md_g_ok, md_l_ok, md_final;

  assign run  = (state_q == RUN);
  assign init = (state_q == INIT);

  assign f_pc    = F_PC_i[IDX_W+1:2];
  assign md_pc   = MD_PC_i[IDX_W+1:2];
  assign f_gidx  = IDX_W'(bp_hash(64'(f_pc), 64'(ghr_q), IDX_W));
  assign f_lidx  = IDX_W'(bp_hash(64'(f_pc), 64'(f_bht), IDX_W));
  assign md_gidx = IDX_W'(bp_hash(64'(md_pc), 64'(MD_ghr_i), IDX_W));
  // Local training index uses the history as it was before this commit shifts it.
  assign md_lidx = IDX_W'(bp_hash(64'(md_pc), 64'(md_bht), IDX_W));

  assign md_train = run & MD_valid_i;
  assign md_g_ok  = (MD_global_predict_i == MD_taken_i);
  assign md_l_ok  = (MD_local_predict_i == MD_taken_i);
  assign md_final = md_cho_old[CHO_W-1] ? MD_global_predict_i : MD_local_predict_i;

  bp_sat_table #(.IDX_W(IDX_W), .W(CTR_W), .SHIFT(1'b0), .INIT_VAL(PHT_INIT)) u_gpht (
    .clk_i, .init_i(init), .init_idx_i(init_idx_q),
    .rd_idx_i(f_gidx), .rd_data_o(f_gctr),
    .wr_en_i(md_train), .wr_idx_i(md_gidx), .wr_bit_i(MD_taken_i), .wr_old_o(md_gold)
  );

  bp_sat_table #(.IDX_W(IDX_W), .W(CTR_W), .SHIFT(1'b0), .INIT_VAL(PHT_INIT)) u_lpht (
    .clk_i, .init_i(init), .init_idx_i(init_idx_q),
    .rd_idx_i(f_lidx), .rd_data_o(f_lctr),
    .wr_en_i(md_train), .wr_idx_i(md_lidx), .wr_bit_i(MD_taken_i), .wr_old_o(md_lold)
  );

  bp_sat_table #(.IDX_W(IDX_W), .W(CHO_W), .SHIFT(1'b0), .INIT_VAL(CHO_INIT)) u_cho (
    .clk_i, .init_i(init), .init_idx_i(init_idx_q),
    .rd_idx_i(f_pc), .rd_data_o(f_cho),
    .wr_en_i(md_train & (md_g_ok ^ md_l_ok)), .wr_idx_i(md_pc), .wr_bit_i(md_g_ok),
    .wr_old_o(md_cho_old)
  );

  bp_sat_table #(.IDX_W(IDX_W), .W(LHR_W), .SHIFT(1'b1), .INIT_VAL('0)) u_bht (
    .clk_i, .init_i(init), .init_idx_i(init_idx_q),
    .rd_idx_i(f_pc), .rd_data_o(f_bht),
    .wr_en_i(md_train), .wr_idx_i(md_pc), .wr_bit_i(MD_taken_i), .wr_old_o(md_bht)
  );

  assign ready_o            = run;
  assign F_global_predict_o = run & f_gctr[CTR_W-1];
  assign F_local_predict_o  = run & f_lctr[CTR_W-1];
  assign F_predict_o        = run & (f_cho[CHO_W-1] ? f_gctr[CTR_W-1] : f_lctr[CTR_W-1]);
  assign F_ghr_o            = run ? ghr_q : '0;
  assign stat_branches_o    = stat_branches_q;
  assign stat_mispred_o     = stat_mispred_q;

  logic unused_bits;
  assign unused_bits = ^{F_PC_i[PC_W-1:IDX_W+2], F_PC_i[1:0], MD_PC_i[PC_W-1:IDX_W+2],
                         MD_PC_i[1:0], ED_ghr_i[GHR_W-1], f_gctr[CTR_W-2:0],
                         f_lctr[CTR_W-2:0], f_cho[CHO_W-2:0], md_cho_old[CHO_W-2:0],
                         md_gold, md_lold};

  always_comb begin
    state_d         = state_q;
    init_idx_d      = init_idx_q;
    ghr_d           = ghr_q;
    stat_branches_d = stat_branches_q;
    stat_mispred_d  = stat_mispred_q;
    case (state_q)
      INIT: begin
        init_idx_d = init_idx_q + IDX_W'(1);
        if (init_idx_q == '1) begin
          state_d = RUN;
        end
      end
      RUN: begin
        // A repair from execute overrides any speculative shift this cycle.
        if (ED_redirect_i) begin
          ghr_d = {ED_ghr_i[GHR_W-2:0], ED_taken_i};
        end else if (F_valid_i && F_is_branch_i) begin
          ghr_d = {ghr_q[GHR_W-2:0], F_predict_o};
        end
        if (MD_valid_i) begin
          stat_branches_d = CNT_W'(sat_inc(64'(stat_branches_q), CNT_W));
          if (md_final != MD_taken_i) begin
            stat_mispred_d = CNT_W'(sat_inc(64'(stat_mispred_q), CNT_W));
          end
        end
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= INIT;
      init_idx_q      <= '0;
      ghr_q           <= '0;
      stat_branches_q <= '0;
      stat_mispred_q  <= '0;
    end else begin
      state_q         <= state_d;
      init_idx_q      <= init_idx_d;
      ghr_q           <= ghr_d;
      stat_branches_q <= stat_branches_d;
      stat_mispred_q  <= stat_mispred_d;
    end
  end

endmodule
